// File: rtl/uart_rx_pkg.sv
// Shared configuration for the UART receiver: bus widths, register decode,
// STATUS bit positions, FSM encodings and a count-saturation helper.
package uart_rx_pkg;

   localparam int SEL_WIDTH = 4;
   localparam int ADR_WIDTH = 32;
   localparam int DAT_WIDTH = 32;
   localparam int TIMER_W   = 16;

   localparam int   ADR_DECODE_BIT = 2;
   localparam logic REG_DATA       = 1'b0;
   localparam logic REG_STATUS     = 1'b1;

   localparam int ST_NEMPTY  = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_OVR     = 2;
   localparam int ST_FERR    = 3;
   localparam int ST_CNT_LSB = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } rx_state_e;

   function automatic logic [3:0] sat_cnt4(input int unsigned n);
      return (n > 32'd15) ? 4'hF : n[3:0];
   endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with receive FIFO behind a two-register Wishbone slave
// (DATA pops the oldest byte, STATUS reports flags and write-1-clears them).
//
// state   | meaning
// S_IDLE  | line idle, waiting for a low level
// S_START | timing half a bit to re-check the start bit in its middle
// S_DATA  | sampling 8 data bits LSB first, one per bit time
// S_STOP  | sampling the stop bit; high pushes, low flags a framing error
// S_BREAK | line held low after a framing error, waiting for it to return high
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 uart_rx_stb_i,
   input  logic                 uart_rx_cyc_i,
   input  logic                 uart_rx_we_i,
   input  logic [SEL_WIDTH-1:0] uart_rx_sel_i,
   input  logic [ADR_WIDTH-1:0] uart_rx_adr_i,
   input  logic [DAT_WIDTH-1:0] uart_rx_dat_i,
   output logic [DAT_WIDTH-1:0] uart_rx_dat_o,
   output logic                 uart_rx_ack_o,
   output logic                 uart_rx_err_o,
   input  logic                 rx_i,
   output logic                 irq_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TIMER_W-1:0] T_FULL = TIMER_W'(CLKS_PER_BIT - 1);
   localparam logic [TIMER_W-1:0] T_HALF = TIMER_W'(CLKS_PER_BIT / 2 - 1);

   logic               rx_meta_q, rx_sync_q;
   rx_state_e          state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               tc, push, ferr_set;

   logic               ack_q, err_q, rd_data_q, rd_stat_q;
   logic [1:0]         clr_q;
   logic               ovr_q, ferr_q;
   logic               wb_req, is_status, ovr_set;

   logic [7:0]         fifo_data;
   logic               fifo_full, fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic [DAT_WIDTH-1:0] status_w;
   logic               unused_bits;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   assign tc = (timer_q == '0);

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      ferr_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               state_d = S_START;
               timer_d = T_HALF;
            end
         end
         S_START: begin
            if (tc) begin
               if (rx_sync_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  timer_d   = T_FULL;
                  bit_idx_d = '0;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_DATA: begin
            if (tc) begin
               shift_d = {rx_sync_q, shift_q[7:1]};
               timer_d = T_FULL;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_STOP: begin
            if (tc) begin
               if (rx_sync_q) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = S_BREAK;
               end
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         S_BREAK: begin
            if (rx_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (rd_data_q),
      .data_i  (shift_q),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // The request is masked while a response is out, so a held strobe is
   // answered every other cycle and each access pops/clears exactly once.
   assign wb_req    = uart_rx_stb_i & uart_rx_cyc_i & ~ack_q & ~err_q;
   assign is_status = (uart_rx_adr_i[ADR_DECODE_BIT] == REG_STATUS);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_data_q <= 1'b0;
         rd_stat_q <= 1'b0;
         clr_q     <= 2'b00;
      end else begin
         ack_q     <= wb_req & ~(uart_rx_we_i & ~is_status);
         err_q     <= wb_req & uart_rx_we_i & ~is_status;
         rd_data_q <= wb_req & ~uart_rx_we_i & ~is_status;
         rd_stat_q <= wb_req & ~uart_rx_we_i & is_status;
         clr_q     <= (wb_req & uart_rx_we_i & is_status & uart_rx_sel_i[0]) ?
                      {uart_rx_dat_i[ST_FERR], uart_rx_dat_i[ST_OVR]} : 2'b00;
      end
   end

   // A full FIFO popped in the same cycle takes the new byte without overrun.
   assign ovr_set = push & fifo_full & ~rd_data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovr_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ovr_q  <= (ovr_q & ~clr_q[0]) | ovr_set;
         ferr_q <= (ferr_q & ~clr_q[1]) | ferr_set;
      end
   end

   always_comb begin
      status_w                    = '0;
      status_w[ST_NEMPTY]         = ~fifo_empty;
      status_w[ST_FULL]           = fifo_full;
      status_w[ST_OVR]            = ovr_q;
      status_w[ST_FERR]           = ferr_q;
      status_w[ST_CNT_LSB +: 4]   = sat_cnt4(32'(fifo_count));
   end

   always_comb begin
      uart_rx_dat_o = '0;
      if (rd_data_q && !fifo_empty) uart_rx_dat_o[7:0] = fifo_data;
      else if (rd_stat_q)           uart_rx_dat_o      = status_w;
   end

   assign uart_rx_ack_o = ack_q;
   assign uart_rx_err_o = err_q;
   assign irq_o         = ~fifo_empty;

   assign unused_bits = ^{uart_rx_adr_i[ADR_WIDTH-1:ADR_DECODE_BIT+1],
                          uart_rx_adr_i[ADR_DECODE_BIT-1:0],
                          uart_rx_sel_i[SEL_WIDTH-1:1],
                          uart_rx_dat_i[DAT_WIDTH-1:ST_FERR+1],
                          uart_rx_dat_i[ST_OVR-1:0]};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 4 clocks per bit and a 4-entry FIFO.
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int CPB = 4;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   logic                 stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [SEL_WIDTH-1:0] sel = '0;
   logic [ADR_WIDTH-1:0] adr = '0;
   logic [DAT_WIDTH-1:0] dat_w = '0;
   logic [DAT_WIDTH-1:0] dat_r;
   logic                 ack, err, irq;
   logic                 rx_i = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .uart_rx_stb_i (stb),
      .uart_rx_cyc_i (cyc),
      .uart_rx_we_i  (we),
      .uart_rx_sel_i (sel),
      .uart_rx_adr_i (adr),
      .uart_rx_dat_i (dat_w),
      .uart_rx_dat_o (dat_r),
      .uart_rx_ack_o (ack),
      .uart_rx_err_o (err),
      .rx_i          (rx_i),
      .irq_o         (irq)
   );

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_bits);
      rx_i = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         wait_cyc(CPB);
      end
      rx_i = stop_lvl;
      wait_cyc(CPB * stop_bits);
      rx_i = 1'b1;
   endtask

   task automatic wb_cycle(input logic wr, input logic a2, input logic [DAT_WIDTH-1:0] wd,
                           input logic [SEL_WIDTH-1:0] s, output logic [DAT_WIDTH-1:0] rd,
                           output logic got_ack, output logic got_err);
      stb = 1'b1; cyc = 1'b1; we = wr; sel = s; dat_w = wd;
      adr = '0;
      adr[ADR_DECODE_BIT] = a2;
      got_ack = 1'b0; got_err = 1'b0; rd = '0;
      for (int i = 0; i < 4 && !got_ack && !got_err; i++) begin
         wait_cyc(1);
         if (ack || err) begin
            got_ack = ack; got_err = err; rd = dat_r;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat_w = '0;
   endtask

   task automatic test_reset();
      logic [DAT_WIDTH-1:0] d; logic a, e;
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %0b expected 0", irq); end
      n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %0b expected 0", ack); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %0b expected 0", err); end
      n_cmp++; if (dat_r !== 32'h0) begin n_bad++; $display("FAIL rst_dat: got %0h expected 0", dat_r); end
      rst_i = 1'b0;
      wait_cyc(2);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rst_stat_ack: got %0b expected 1", a); end
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_status: got %0h expected 0", d); end
   endtask

   task automatic test_single_frame();
      logic [DAT_WIDTH-1:0] d; logic a, e;
      send_frame(8'hA5, 1'b1, 1);
      wait_cyc(2);
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL a5_irq: got %0b expected 1", irq); end
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h11) begin n_bad++; $display("FAIL a5_status: got %0h expected 11", d); end
      wb_cycle(1'b0, REG_DATA, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'hA5) begin n_bad++; $display("FAIL a5_data: got %0h expected a5", d); end
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h00) begin n_bad++; $display("FAIL a5_status_after: got %0h expected 0", d); end
   endtask

   task automatic test_overrun();
      logic [DAT_WIDTH-1:0] d; logic a, e;
      logic [7:0] exp_b;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1);
      wait_cyc(3);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h47) begin n_bad++; $display("FAIL ovr_status_full: got %0h expected 47", d); end
      for (int i = 1; i <= 4; i++) begin
         exp_b = 8'(i);
         wb_cycle(1'b0, REG_DATA, '0, 4'hF, d, a, e);
         n_cmp++; if (d !== {24'h0, exp_b}) begin n_bad++; $display("FAIL ovr_data%0d: got %0h expected %0h", i, d, exp_b); end
      end
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h04) begin n_bad++; $display("FAIL ovr_status_drained: got %0h expected 4", d); end
      wb_cycle(1'b1, REG_STATUS, 32'h4, 4'h0, d, a, e);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL ovr_nosel_ack: got %0b expected 1", a); end
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h04) begin n_bad++; $display("FAIL ovr_nosel_status: got %0h expected 4", d); end
      wb_cycle(1'b1, REG_STATUS, 32'h4, 4'h1, d, a, e);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h00) begin n_bad++; $display("FAIL ovr_cleared: got %0h expected 0", d); end
   endtask

   task automatic test_framing();
      logic [DAT_WIDTH-1:0] d; logic a, e;
      send_frame(8'h3C, 1'b0, 20);
      wait_cyc(8);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h08) begin n_bad++; $display("FAIL ferr_status: got %0h expected 8", d); end
      send_frame(8'h7E, 1'b1, 1);
      wait_cyc(3);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h19) begin n_bad++; $display("FAIL ferr_next_status: got %0h expected 19", d); end
      wb_cycle(1'b0, REG_DATA, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h7E) begin n_bad++; $display("FAIL ferr_next_data: got %0h expected 7e", d); end
      wb_cycle(1'b1, REG_STATUS, 32'h8, 4'h1, d, a, e);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h00) begin n_bad++; $display("FAIL ferr_cleared: got %0h expected 0", d); end
   endtask

   task automatic test_glitch();
      logic [DAT_WIDTH-1:0] d; logic a, e;
      rx_i = 1'b0;
      wait_cyc(1);
      rx_i = 1'b1;
      wait_cyc(12);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL glitch_irq: got %0b expected 0", irq); end
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h00) begin n_bad++; $display("FAIL glitch_status: got %0h expected 0", d); end
      send_frame(8'hC3, 1'b1, 1);
      wait_cyc(3);
      wb_cycle(1'b0, REG_DATA, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'hC3) begin n_bad++; $display("FAIL glitch_next_data: got %0h expected c3", d); end
   endtask

   task automatic test_bus_errors();
      logic [DAT_WIDTH-1:0] d; logic a, e;
      int acks;
      wb_cycle(1'b1, REG_DATA, 32'hFF, 4'hF, d, a, e);
      n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL wr_data_err: got %0b expected 1", e); end
      n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL wr_data_ack: got %0b expected 0", a); end
      wait_cyc(1);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wr_data_err_pulse: got %0b expected 0", err); end
      wb_cycle(1'b0, REG_DATA, '0, 4'hF, d, a, e);
      n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rd_empty_ack: got %0b expected 1", a); end
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rd_empty_data: got %0h expected 0", d); end
      // held strobe for four cycles
      stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'hF;
      adr = '0; adr[ADR_DECODE_BIT] = REG_STATUS;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
         wait_cyc(1);
         if (ack) acks++;
      end
      stb = 1'b0; cyc = 1'b0;
      wait_cyc(1);
      n_cmp++; if (acks !== 2) begin n_bad++; $display("FAIL held_stb_acks: got %0d expected 2", acks); end
   endtask

   task automatic test_reset_midframe();
      logic [DAT_WIDTH-1:0] d; logic a, e;
      logic [7:0] b;
      send_frame(8'h99, 1'b1, 1);
      wait_cyc(3);
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL mid_pre_irq: got %0b expected 1", irq); end
      b = 8'h12;
      rx_i = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_i = b[i];
         wait_cyc(CPB);
      end
      rx_i = b[4];
      wait_cyc(2);
      rst_i = 1'b1;
      rx_i = 1'b1;
      #1;
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_rst_irq: got %0b expected 0", irq); end
      n_cmp++; if ({ack, err} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_ack_err: got %0b expected 00", {ack, err}); end
      n_cmp++; if (dat_r !== 32'h0) begin n_bad++; $display("FAIL mid_rst_dat: got %0h expected 0", dat_r); end
      wait_cyc(2);
      rst_i = 1'b0;
      wait_cyc(8);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h00) begin n_bad++; $display("FAIL mid_post_status: got %0h expected 0", d); end
      send_frame(8'h55, 1'b1, 1);
      wait_cyc(3);
      wb_cycle(1'b0, REG_STATUS, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h11) begin n_bad++; $display("FAIL mid_55_status: got %0h expected 11", d); end
      wb_cycle(1'b0, REG_DATA, '0, 4'hF, d, a, e);
      n_cmp++; if (d !== 32'h55) begin n_bad++; $display("FAIL mid_55_data: got %0h expected 55", d); end
   endtask

   initial begin
      @(negedge clk_i);
      test_reset();
      test_single_frame();
      test_overrun();
      test_framing();
      test_glitch();
      test_bus_errors();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at time limit");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk_i cycles per serial bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries; power of two, 2..64.
REQ-003 SHALL have clk_i  in  1  the single clock; all logic rising-edge.
REQ-004 SHALL have rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have uart_rx_stb_i  in  1  Wishbone strobe (slave select from intercon).
REQ-006 SHALL have uart_rx_cyc_i  in  1  Wishbone cycle.
REQ-007 SHALL have uart_rx_we_i  in  1  Wishbone write enable.
REQ-008 SHALL have uart_rx_sel_i  in  `SEL_WIDTH  byte selects.
REQ-009 SHALL have uart_rx_adr_i  in  `ADR_WIDTH  byte address; only bit 2 decoded.
REQ-010 SHALL have uart_rx_dat_i  in  `DAT_WIDTH  write data.
REQ-011 SHALL have uart_rx_dat_o  out  `DAT_WIDTH  read data.
REQ-012 SHALL have uart_rx_ack_o  out  1  Wishbone acknowledge.
REQ-013 SHALL have uart_rx_err_o  out  1  Wishbone error.
REQ-014 SHALL have rx_i  in  1  asynchronous serial line, idle high, 8N1.
REQ-015 SHALL have irq_o  out  1  high while FIFO non-empty.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchronizer; all FSM sampling uses the synchronized value.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK with a bit-timer counter and 3-bit bit index.
REQ-018 IDLE: synchronized low -> START, timer loaded for CLKS_PER_BIT/2.
REQ-019 START: at timer expiry, sample high -> IDLE (glitch, nothing recorded); sample low -> DATA, timer CLKS_PER_BIT.
REQ-020 DATA: sample at each expiry, LSB first, 8 bits, then -> STOP.
REQ-021 STOP: sample high -> push byte, -> IDLE; sample low -> discard byte, set FERR, -> BREAK.
REQ-022 BREAK: remain until synchronized high, then -> IDLE.
REQ-023 Push when FIFO full SHALL drop the byte, set sticky OVR, leave FIFO unchanged.
REQ-024 Register map: adr[2]=0 DATA, adr[2]=1 STATUS.
REQ-025 DATA read SHALL return {zeros, oldest byte} and pop it; read on empty returns 0, no state change.
REQ-026 STATUS read SHALL return bit0 NEMPTY, bit1 FULL, bit2 OVR, bit3 FERR, bits[7:4] entry count (saturating at 15), rest 0.
REQ-027 STATUS write with sel[0]=1 SHALL clear OVR/FERR where dat_i bit is 1; other bits ignored; sel[0]=0 write is acked with no effect.
REQ-028 DATA write SHALL assert err_o instead of ack_o, no side effect.
REQ-029 Response SHALL be registered, one cycle after stb&cyc, single-cycle pulse; ack_o = stb&cyc&~ack_o&~err_o so a held strobe yields one response per two cycles; pop/clear occur in the response cycle only.
REQ-030 Simultaneous push and pop SHALL both take effect; count unchanged; push into full FIFO in the pop cycle SHALL succeed.
REQ-031 Simultaneous OVR/FERR set and software clear SHALL leave the bit set.
REQ-032 dat_o SHALL be valid only while ack_o is high; 0 otherwise.

Reset
REQ-033 rst_i SHALL asynchronously force: FSM IDLE, synchronizer flops high, FIFO empty, pointers 0, OVR/FERR 0, ack_o/err_o 0, dat_o 0, irq_o 0.
REQ-034 Reset mid-frame SHALL abandon the frame; the first push after release requires a fresh start bit.

Structure
REQ-035 Register offsets, STATUS bit positions and FSM state encodings SHALL live in the shared config.v header alongside the Wishbone width constants.
REQ-036 The FIFO SHALL be a sub-module named sync_fifo (push, pop, data, full, empty, count), reusable for a future transmit path.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-037 Send 0xA5 8N1 -> irq_o rises within 2 cycles after stop sample; STATUS read = 0x11; DATA read = 0xA5; then STATUS = 0x00.
REQ-038 Send 0x01..0x05 without reads -> DATA reads return 0x01..0x04, STATUS OVR=1; write 0x4 to STATUS -> OVR=0.
REQ-039 Frame 0x3C with stop bit low held 20 bit-times -> FERR=1, FIFO empty; next frame 0x7E received correctly after line high.
REQ-040 Low glitch of 1 cycle on idle rx_i -> no push, no FERR, FSM back in IDLE.
REQ-041 Write to DATA -> err_o one cycle, ack_o 0; read DATA on empty -> ack_o, dat_o 0.
REQ-042 Assert rst_i during bit 4 of a frame -> all outputs 0 immediately; following frame 0x55 received as 0x55.
